legv8_control_fsm: RTL and testbench

- Multi-cycle control unit for the LEGv8 core: the producer of the 93-bit control word that the datapath consumes.
- Latches the 32-bit instruction from the instruction ROM (addressed by the program counter) and decodes it.
- Issues per-state control words that drive the register file, ALU, status register, data memory, bus enables and PC.
- Reads flag status back from the datapath to resolve conditional branches.

---
 rtl/legv8_pkg.sv | 108 ++++++++++
 rtl/legv8_control_fsm_decoder.sv | 150 +++++++++++++++
 rtl/legv8_control_fsm.sv | 67 ++++++
 tb/tb_legv8_control_fsm.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// Shared definitions for the LEGv8 multi-cycle control unit: FSM state
// encodings, instruction opcodes, ALU function select (FS), PC source select
// (PS), branch condition codes and the bit map of the control word.
package legv8_pkg;

  typedef enum logic [1:0] {
    S_FETCH = 2'b00,
    S_EXEC  = 2'b01,
    S_EXEC2 = 2'b10,
    S_HALT  = 2'b11
  } state_e;

  // 11-bit opcodes, IR[31:21] (R-type, D-type, BR)
  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_ADDS = 11'h558;
  localparam logic [10:0] OP_SUB  = 11'h658;
  localparam logic [10:0] OP_SUBS = 11'h758;
  localparam logic [10:0] OP_AND  = 11'h450;
  localparam logic [10:0] OP_ANDS = 11'h750;
  localparam logic [10:0] OP_ORR  = 11'h550;
  localparam logic [10:0] OP_EOR  = 11'h650;
  localparam logic [10:0] OP_LSL  = 11'h69B;
  localparam logic [10:0] OP_LSR  = 11'h69A;
  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;
  localparam logic [10:0] OP_BR   = 11'h6B0;
  // 10-bit opcodes, IR[31:22] (I-type)
  localparam logic [9:0]  OP_ADDI = 10'h244;
  localparam logic [9:0]  OP_SUBI = 10'h344;
  localparam logic [9:0]  OP_ANDI = 10'h248;
  localparam logic [9:0]  OP_ORRI = 10'h2C8;
  localparam logic [9:0]  OP_EORI = 10'h348;
  // 9-bit opcode, IR[31:23]
  localparam logic [8:0]  OP_MOVZ = 9'h1A5;
  // 8-bit opcodes, IR[31:24]
  localparam logic [7:0]  OP_CBZ   = 8'hB4;
  localparam logic [7:0]  OP_CBNZ  = 8'hB5;
  localparam logic [7:0]  OP_BCOND = 8'h54;
  // 6-bit opcodes, IR[31:26]
  localparam logic [5:0]  OP_B    = 6'h05;
  localparam logic [5:0]  OP_BL   = 6'h25;

  // ALU function select; FS[0] is also the ALU carry-in
  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_ORR = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;
  localparam logic [4:0] FS_EOR = 5'b01100;
  localparam logic [4:0] FS_LSL = 5'b10000;
  localparam logic [4:0] FS_LSR = 5'b10100;

  // PC source select
  localparam logic [1:0] PS_HOLD   = 2'b00;
  localparam logic [1:0] PS_INC    = 2'b01;
  localparam logic [1:0] PS_OFFSET = 2'b10;
  localparam logic [1:0] PS_REG    = 2'b11;

  localparam logic [4:0] REG_XZR = 5'd31;
  localparam logic [4:0] REG_LR  = 5'd30;

  // B.cond condition codes
  localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_HS = 4'h2, COND_LO = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF;

  // Control word bit map, LSB first. The PC source is carried entirely by PS,
  // so there is no separate PC-select bit and the word is DATA_WIDTH+29 wide.
  localparam int DA_LSB     = 0;
  localparam int SA_LSB     = 5;
  localparam int SB_LSB     = 10;
  localparam int FS_LSB     = 15;
  localparam int PS_LSB     = 20;
  localparam int WR_BIT     = 22;
  localparam int WM_BIT     = 23;
  localparam int SL_BIT     = 24;
  localparam int BSEL_BIT   = 25;
  localparam int EN_ALU_BIT = 26;
  localparam int EN_MEM_BIT = 27;
  localparam int EN_PC_BIT  = 28;
  localparam int K_LSB      = 29;

  // flags = {V,C,N,Z}
  function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] flags);
    logic v, c, n, z, t;
    {v, c, n, z} = flags;
    case (cond)
      COND_EQ: t = z;
      COND_NE: t = ~z;
      COND_HS: t = c;
      COND_LO: t = ~c;
      COND_MI: t = n;
      COND_PL: t = ~n;
      COND_VS: t = v;
      COND_VC: t = ~v;
      COND_HI: t = c & ~z;
      COND_LS: t = ~(c & ~z);
      COND_GE: t = (n == v);
      COND_LT: t = (n != v);
      COND_GT: t = ~z & (n == v);
      COND_LE: t = ~(~z & (n == v));
      COND_AL, COND_NV: t = 1'b1;
      default: t = 1'b1;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/legv8_control_fsm_decoder.sv
// Combinational decoder: latched IR + datapath status -> control word for the
// EXEC and EXEC2 states. Outside those states it produces the all-zero NOP word.
//   state        in   current FSM state
//   ir           in   latched instruction
//   status       in   {V,C,N,Z} registered flags in [4:1], live ALU zero in [0]
//   control_word out  datapath control word
//   illegal      out  EXEC saw an unrecognised opcode
//   is_bl        out  EXEC is the first half of BL
module legv8_decoder
  import legv8_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CW_WIDTH   = DATA_WIDTH + 29
) (
  input  state_e              state,
  input  logic [31:0]         ir,
  input  logic [4:0]          status,
  output logic [CW_WIDTH-1:0] control_word,
  output logic                illegal,
  output logic                is_bl
);

  logic [10:0] op11;
  logic [9:0]  op10;
  logic [8:0]  op9;
  logic [7:0]  op8;
  logic [5:0]  op6;
  logic [4:0]  rd, rn, rm;

  assign op11 = ir[31:21];
  assign op10 = ir[31:22];
  assign op9  = ir[31:23];
  assign op8  = ir[31:24];
  assign op6  = ir[31:26];
  assign rd   = ir[4:0];
  assign rn   = ir[9:5];
  assign rm   = ir[20:16];

  logic [DATA_WIDTH-1:0] k_i12, k_d9, k_b26, k_b19, k_movz, k_shamt;
  assign k_i12   = {{(DATA_WIDTH-12){1'b0}}, ir[21:10]};
  assign k_d9    = {{(DATA_WIDTH-9){ir[20]}}, ir[20:12]};
  assign k_b26   = {{(DATA_WIDTH-28){ir[25]}}, ir[25:0], 2'b00};
  assign k_b19   = {{(DATA_WIDTH-21){ir[23]}}, ir[23:5], 2'b00};
  assign k_movz  = {{(DATA_WIDTH-16){1'b0}}, ir[20:5]} << {ir[22:21], 4'b0000};
  assign k_shamt = {{(DATA_WIDTH-6){1'b0}}, ir[15:10]};

  // ALU-class opcode lookups kept apart from the main decode
  logic       r_hit, r_sl, i_hit;
  logic [4:0] r_fs, i_fs;

  always_comb begin
    r_hit = 1'b1;
    r_sl  = 1'b0;
    r_fs  = FS_AND;
    case (op11)
      OP_ADD:  r_fs = FS_ADD;
      OP_ADDS: begin r_fs = FS_ADD; r_sl = 1'b1; end
      OP_SUB:  r_fs = FS_SUB;
      OP_SUBS: begin r_fs = FS_SUB; r_sl = 1'b1; end
      OP_AND:  r_fs = FS_AND;
      OP_ANDS: begin r_fs = FS_AND; r_sl = 1'b1; end
      OP_ORR:  r_fs = FS_ORR;
      OP_EOR:  r_fs = FS_EOR;
      default: r_hit = 1'b0;
    endcase
    i_hit = 1'b1;
    i_fs  = FS_AND;
    case (op10)
      OP_ADDI: i_fs = FS_ADD;
      OP_SUBI: i_fs = FS_SUB;
      OP_ANDI: i_fs = FS_AND;
      OP_ORRI: i_fs = FS_ORR;
      OP_EORI: i_fs = FS_EOR;
      default: i_hit = 1'b0;
    endcase
  end

  logic [DATA_WIDTH-1:0] k;
  logic                  en_pc, en_mem, en_alu, bsel, sl, wm, wr;
  logic [1:0]            ps;
  logic [4:0]            fs, sb, sa, da;

  always_comb begin
    k = '0; en_pc = 1'b0; en_mem = 1'b0; en_alu = 1'b0; bsel = 1'b0;
    sl = 1'b0; wm = 1'b0; wr = 1'b0; ps = PS_HOLD; fs = FS_AND;
    sb = '0; sa = '0; da = '0;
    illegal = 1'b0;
    is_bl   = 1'b0;
    if (state == S_EXEC2) begin
      // second half of BL: IR still holds the BL, take the branch
      ps = PS_OFFSET; k = k_b26;
    end else if (state == S_EXEC) begin
      if (r_hit) begin
        sa = rn; sb = rm; da = rd; fs = r_fs; sl = r_sl;
        en_alu = 1'b1; wr = 1'b1; ps = PS_INC;
      end else if (op11 == OP_LSL || op11 == OP_LSR) begin
        sa = rn; da = rd; bsel = 1'b1; k = k_shamt;
        fs = (op11 == OP_LSL) ? FS_LSL : FS_LSR;
        en_alu = 1'b1; wr = 1'b1; ps = PS_INC;
      end else if (op11 == OP_LDUR) begin
        sa = rn; da = rd; bsel = 1'b1; k = k_d9; fs = FS_ADD;
        en_mem = 1'b1; wr = 1'b1; ps = PS_INC;
      end else if (op11 == OP_STUR) begin
        sa = rn; sb = rd; bsel = 1'b1; k = k_d9; fs = FS_ADD;
        wm = 1'b1; ps = PS_INC;
      end else if (op11 == OP_BR) begin
        sa = rn; ps = PS_REG;
      end else if (op9 == OP_MOVZ) begin
        sa = REG_XZR; da = rd; bsel = 1'b1; k = k_movz; fs = FS_ORR;
        en_alu = 1'b1; wr = 1'b1; ps = PS_INC;
      end else if (i_hit) begin
        sa = rn; da = rd; bsel = 1'b1; k = k_i12; fs = i_fs;
        en_alu = 1'b1; wr = 1'b1; ps = PS_INC;
      end else if (op8 == OP_CBZ || op8 == OP_CBNZ) begin
        // XZR | Rt passes Rt through the ALU so status[0] reflects Rt==0.
        // PS never feeds back into the ALU, so this is loop-free.
        sa = REG_XZR; sb = rd; fs = FS_ORR; k = k_b19;
        ps = (status[0] ^ (op8 == OP_CBNZ)) ? PS_OFFSET : PS_INC;
      end else if (op8 == OP_BCOND) begin
        k  = k_b19;
        ps = cond_holds(ir[3:0], status[4:1]) ? PS_OFFSET : PS_INC;
      end else if (op6 == OP_B) begin
        k = k_b26; ps = PS_OFFSET;
      end else if (op6 == OP_BL) begin
        // PC drives the bus (PC+4) into X30; PC holds until EXEC2
        en_pc = 1'b1; da = REG_LR; wr = 1'b1; is_bl = 1'b1;
      end else begin
        illegal = 1'b1;
      end
    end
  end

  always_comb begin
    control_word = '0;
    control_word[DA_LSB +: 5]          = da;
    control_word[SA_LSB +: 5]          = sa;
    control_word[SB_LSB +: 5]          = sb;
    control_word[FS_LSB +: 5]          = fs;
    control_word[PS_LSB +: 2]          = ps;
    control_word[WR_BIT]               = wr;
    control_word[WM_BIT]               = wm;
    control_word[SL_BIT]               = sl;
    control_word[BSEL_BIT]             = bsel;
    control_word[EN_ALU_BIT]           = en_alu;
    control_word[EN_MEM_BIT]           = en_mem;
    control_word[EN_PC_BIT]            = en_pc;
    control_word[K_LSB +: DATA_WIDTH]  = k;
  end

endmodule

// File: rtl/legv8_control_fsm.sv
// LEGv8 multi-cycle control unit. FETCH latches the instruction into IR,
// EXEC (and EXEC2 for BL) issue the decoded control word, unrecognised
// opcodes park the unit in HALT until reset.
//   clock        in   system clock
//   reset        in   async active-high reset
//   instruction  in   instruction ROM output at the current PC
//   status       in   {V,C,N,Z} flags in [4:1], live ALU zero in [0]
//   control_word out  {constant, EN_PC, EN_Mem, EN_ALU, Bsel, SL, WM, WR, PS, FS, SB, SA, DA}
//   state        out  current FSM state
//   halted       out  high in HALT
module legv8_control_fsm
  import legv8_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CW_WIDTH   = DATA_WIDTH + 29
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [31:0]         instruction,
  input  logic [4:0]          status,
  output logic [CW_WIDTH-1:0] control_word,
  output logic [1:0]          state,
  output logic                halted
);

  state_e      state_q, state_d;
  logic [31:0] ir_q;
  logic        illegal, is_bl;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH) ir_q <= instruction;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: state_d = S_EXEC;
      S_EXEC:  state_d = illegal ? S_HALT : (is_bl ? S_EXEC2 : S_FETCH);
      S_EXEC2: state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
    state  = state_q;
    halted = (state_q == S_HALT);
  end

  // Word is purely combinational from state, so an async reset forces the
  // NOP word in the same instant the state returns to FETCH.
  legv8_decoder #(.DATA_WIDTH(DATA_WIDTH), .CW_WIDTH(CW_WIDTH)) u_dec (
    .state        (state_q),
    .ir           (ir_q),
    .status       (status),
    .control_word (control_word),
    .illegal      (illegal),
    .is_bl        (is_bl)
  );

  a_bus_exclusive: assert property (@(posedge clock) disable iff (reset)
    $onehot0({control_word[EN_PC_BIT], control_word[EN_MEM_BIT], control_word[EN_ALU_BIT]}));

endmodule

// File: tb/tb_legv8_control_fsm.sv
module tb_legv8_control_fsm;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instruction = '0;
  logic [4:0]  status = '0;
  logic [92:0] control_word;
  logic [1:0]  dut_state;
  logic        halted;

  int checks = 0;
  int failures = 0;

  legv8_control_fsm dut (
    .clock        (clock),
    .reset        (reset),
    .instruction  (instruction),
    .status       (status),
    .control_word (control_word),
    .state        (dut_state),
    .halted       (halted)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ISA tables
  logic [10:0] r_op [8] = '{11'h458, 11'h558, 11'h658, 11'h758, 11'h450, 11'h750, 11'h550, 11'h650};
  logic [4:0]  r_fs [8] = '{5'b01000, 5'b01000, 5'b01001, 5'b01001, 5'b00000, 5'b00000, 5'b00100, 5'b01100};
  bit          r_sl [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [9:0]  i_op [5] = '{10'h244, 10'h344, 10'h248, 10'h2C8, 10'h348};
  logic [4:0]  i_fs [5] = '{5'b01000, 5'b01001, 5'b00000, 5'b00100, 5'b01100};

  // f = {EN_PC, EN_Mem, EN_ALU, Bsel, SL, WM, WR}
  function automatic logic [92:0] cw(input logic [63:0] k, input logic [6:0] f,
                                     input logic [1:0] ps, input logic [4:0] fs, sb, sa, da);
    return {k, f, ps, fs, sb, sa, da};
  endfunction

  // flags = {V,C,N,Z}
  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] flags);
    bit v, cc, n, z;
    v = flags[3]; cc = flags[2]; n = flags[1]; z = flags[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cc;
      4'd3:  return !cc;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cc && !z;
      4'd9:  return !(cc && !z);
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return !(!z && (n == v));
      default: return 1'b1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Entered just after a negedge with the DUT in FETCH; leaves at the negedge
  // that starts the next FETCH.
  task automatic run(input logic [31:0] ins, input logic [4:0] st, input logic [92:0] e1,
                     input bit two, input logic [92:0] e2, input string tag);
    instruction = ins;
    status = 5'($urandom);
    #1;
    chk({tag, "/fetch_state"}, 96'(dut_state), 96'(2'd0));
    chk({tag, "/fetch_cw"}, 96'(control_word), 96'(0));
    @(negedge clock);
    instruction = $urandom;   // PC has moved on; IR must hold
    status = st;
    #1;
    chk({tag, "/exec_state"}, 96'(dut_state), 96'(2'd1));
    chk({tag, "/exec_cw"}, 96'(control_word), 96'(e1));
    if (two) begin
      @(negedge clock);
      #1;
      chk({tag, "/exec2_state"}, 96'(dut_state), 96'(2'd2));
      chk({tag, "/exec2_cw"}, 96'(control_word), 96'(e2));
    end
    @(negedge clock);
  endtask

  initial begin
    logic [31:0] ins;
    logic [4:0]  st, rd, rn, rm;
    logic [5:0]  sh;
    logic [1:0]  hw;
    logic [11:0] imm12;
    logic [15:0] imm16;
    logic [3:0]  c;
    logic [63:0] k;
    logic [92:0] e1, e2;
    int          off, kind, idx;
    bit          two, nz, taken, lr;

    // reset
    instruction = 32'h910017E1;
    repeat (2) @(negedge clock);
    #1;
    chk("reset_state", 96'(dut_state), 96'(2'd0));
    chk("reset_cw", 96'(control_word), 96'(0));
    chk("reset_halted", 96'(halted), 96'(1'b0));
    @(negedge clock);
    reset = 1'b0;

    // ADDI X1,XZR,#5
    run(32'h910017E1, 5'd0, cw(64'd5, 7'b0011001, 2'b01, 5'b01000, 5'd0, 5'd31, 5'd1), 1'b0, '0, "addi");
    // LDUR X2,[X1,#-8]
    run({11'h7C2, 9'h1F8, 2'b00, 5'd1, 5'd2}, 5'd0,
        cw(64'hFFFF_FFFF_FFFF_FFF8, 7'b0101001, 2'b01, 5'b01000, 5'd0, 5'd1, 5'd2), 1'b0, '0, "ldur");
    // STUR X2,[X1,#-8]
    run({11'h7C0, 9'h1F8, 2'b00, 5'd1, 5'd2}, 5'd0,
        cw(64'hFFFF_FFFF_FFFF_FFF8, 7'b0001010, 2'b01, 5'b01000, 5'd2, 5'd1, 5'd0), 1'b0, '0, "stur");
    // CBZ X3,+4 words
    run({8'hB4, 19'd4, 5'd3}, 5'b00001, cw(64'd16, 7'b0, 2'b10, 5'b00100, 5'd3, 5'd31, 5'd0), 1'b0, '0, "cbz_taken");
    run({8'hB4, 19'd4, 5'd3}, 5'b00000, cw(64'd16, 7'b0, 2'b01, 5'b00100, 5'd3, 5'd31, 5'd0), 1'b0, '0, "cbz_not");
    // B.GT +2 words
    run({8'h54, 19'd2, 1'b0, 4'hC}, 5'b10100, cw(64'd8, 7'b0, 2'b10, 5'd0, 5'd0, 5'd0, 5'd0), 1'b0, '0, "bgt_taken");
    run({8'h54, 19'd2, 1'b0, 4'hC}, 5'b00010, cw(64'd8, 7'b0, 2'b01, 5'd0, 5'd0, 5'd0, 5'd0), 1'b0, '0, "bgt_not");
    // BL +3 words
    run({6'b100101, 26'd3}, 5'd0, cw(64'd0, 7'b1000001, 2'b00, 5'd0, 5'd0, 5'd0, 5'd30), 1'b1,
        cw(64'd12, 7'b0, 2'b10, 5'd0, 5'd0, 5'd0, 5'd0), "bl");
    // MOVZ X7,#0xBEEF,LSL #48
    run({9'h1A5, 2'd3, 16'hBEEF, 5'd7}, 5'd0,
        cw(64'hBEEF_0000_0000_0000, 7'b0011001, 2'b01, 5'b00100, 5'd0, 5'd31, 5'd7), 1'b0, '0, "movz_hw3");

    // randomized instruction mix against the assembly-level model
    for (int it = 0; it < 120; it++) begin
      kind = int'($urandom_range(10, 0));
      rd = 5'($urandom); rn = 5'($urandom); rm = 5'($urandom);
      st = 5'($urandom);
      two = 1'b0; e2 = '0; ins = '0; e1 = '0;
      case (kind)
        0: begin
          idx = int'($urandom_range(7, 0));
          ins = {r_op[idx], rm, 6'd0, rn, rd};
          e1 = cw(64'd0, {4'b0010, r_sl[idx], 2'b01}, 2'b01, r_fs[idx], rm, rn, rd);
        end
        1: begin
          idx = int'($urandom_range(4, 0));
          imm12 = 12'($urandom);
          ins = {i_op[idx], imm12, rn, rd};
          e1 = cw(64'(imm12), 7'b0011001, 2'b01, i_fs[idx], 5'd0, rn, rd);
        end
        2: begin
          sh = 6'($urandom);
          lr = 1'($urandom);
          ins = {lr ? 11'h69A : 11'h69B, rm, sh, rn, rd};
          e1 = cw(64'(sh), 7'b0011001, 2'b01, lr ? 5'b10100 : 5'b10000, 5'd0, rn, rd);
        end
        3: begin
          hw = 2'($urandom);
          imm16 = 16'($urandom);
          ins = {9'h1A5, hw, imm16, rd};
          k = 64'(imm16) << (16 * int'(hw));
          e1 = cw(k, 7'b0011001, 2'b01, 5'b00100, 5'd0, 5'd31, rd);
        end
        4, 5: begin
          off = int'($urandom_range(511, 0)) - 256;
          k = longint'(off);
          if (kind == 4) begin
            ins = {11'h7C2, 9'(off), 2'b00, rn, rd};
            e1 = cw(k, 7'b0101001, 2'b01, 5'b01000, 5'd0, rn, rd);
          end else begin
            ins = {11'h7C0, 9'(off), 2'b00, rn, rd};
            e1 = cw(k, 7'b0001010, 2'b01, 5'b01000, rd, rn, 5'd0);
          end
        end
        6, 10: begin
          off = int'($urandom_range(32'h03FF_FFFF, 0)) - 32'sh0200_0000;
          k = longint'(off) * 4;
          if (kind == 6) begin
            ins = {6'b000101, 26'(off)};
            e1 = cw(k, 7'b0, 2'b10, 5'd0, 5'd0, 5'd0, 5'd0);
          end else begin
            ins = {6'b100101, 26'(off)};
            e1 = cw(64'd0, 7'b1000001, 2'b00, 5'd0, 5'd0, 5'd0, 5'd30);
            two = 1'b1;
            e2 = cw(k, 7'b0, 2'b10, 5'd0, 5'd0, 5'd0, 5'd0);
          end
        end
        7: begin
          ins = {11'h6B0, rm, 6'd0, rn, rd};
          e1 = cw(64'd0, 7'b0, 2'b11, 5'd0, 5'd0, rn, 5'd0);
        end
        8: begin
          off = int'($urandom_range(32'h0007_FFFF, 0)) - 32'sh0004_0000;
          k = longint'(off) * 4;
          nz = 1'($urandom);
          ins = {nz ? 8'hB5 : 8'hB4, 19'(off), rd};
          taken = nz ? !st[0] : st[0];
          e1 = cw(k, 7'b0, taken ? 2'b10 : 2'b01, 5'b00100, rd, 5'd31, 5'd0);
        end
        default: begin
          off = int'($urandom_range(32'h0007_FFFF, 0)) - 32'sh0004_0000;
          k = longint'(off) * 4;
          c = 4'($urandom);
          ins = {8'h54, 19'(off), 1'b0, c};
          taken = cond_ok(c, st[4:1]);
          e1 = cw(k, 7'b0, taken ? 2'b10 : 2'b01, 5'd0, 5'd0, 5'd0, 5'd0);
        end
      endcase
      run(ins, st, e1, two, e2, $sformatf("rand%0d_k%0d", it, kind));
    end

    // unrecognised opcode -> HALT
    instruction = 32'h0000_0000;
    #1;
    chk("halt_fetch_state", 96'(dut_state), 96'(2'd0));
    @(negedge clock);
    #1;
    chk("halt_exec_state", 96'(dut_state), 96'(2'd1));
    chk("halt_exec_cw", 96'(control_word), 96'(0));
    chk("halt_exec_halted", 96'(halted), 96'(1'b0));
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      instruction = 32'h910017E1;
      #1;
      chk($sformatf("halt%0d_state", i), 96'(dut_state), 96'(2'd3));
      chk($sformatf("halt%0d_halted", i), 96'(halted), 96'(1'b1));
      chk($sformatf("halt%0d_cw", i), 96'(control_word), 96'(0));
    end
    reset = 1'b1;
    #1;
    chk("halt_reset_state", 96'(dut_state), 96'(2'd0));
    chk("halt_reset_halted", 96'(halted), 96'(1'b0));
    @(negedge clock);
    reset = 1'b0;

    // reset in the middle of EXEC of ADD X3,X1,X2
    instruction = {11'h458, 5'd2, 6'd0, 5'd1, 5'd3};
    #1;
    chk("mid_fetch_state", 96'(dut_state), 96'(2'd0));
    @(negedge clock);
    #1;
    chk("mid_exec_cw", 96'(control_word), 96'(cw(64'd0, 7'b0010001, 2'b01, 5'b01000, 5'd2, 5'd1, 5'd3)));
    reset = 1'b1;
    #1;
    chk("mid_reset_cw", 96'(control_word), 96'(0));
    chk("mid_reset_state", 96'(dut_state), 96'(2'd0));
    @(negedge clock);
    reset = 1'b0;
    // first cycle after release must be a clean FETCH, then normal flow
    run(32'h910017E1, 5'd0, cw(64'd5, 7'b0011001, 2'b01, 5'b01000, 5'd0, 5'd31, 5'd1), 1'b0, '0, "post_reset_addi");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
